rw_ram_sync_param: RTL and testbench

//  Parametrised single-port synchronous RAM: the clocked, generalised successor to the
//  4x4 asynchronous read/write array.
//  - Registered write; pipelined read with configurable latency and a read-valid strobe.
//  - Optional hardware clear sequencer zeroes every word after reset.
//  - Storage block for the lab datapaths (scratch buffers, lookup tables).

---
 rtl/rw_ram_sync_param.sv | 110 +++++++++++
 tb/tb_rw_ram_sync_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_ram_sync_param.sv
// Single-port synchronous RAM with registered write, 1- or 2-cycle pipelined read,
// and an optional post-reset sequencer that zeroes every word.
module rw_ram_sync_param #(
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DEPTH          = 2 ** ADDR_W,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic              rd_req;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastAddr) state_d = StReady;
      end
      StReady: ;
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StReady;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign in_range = ({1'b0, address} < DepthExt);
  assign accept   = en && (state_q == StReady);
  assign wr_en    = accept && we && in_range;
  assign rd_req   = accept && !we;
  assign rd_word  = in_range ? mem[address] : '0;

  // No reset on the array; the clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      mem[address] <= data_in;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              p1_valid_q;
    logic [DATA_W-1:0] p1_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p1_valid_q <= 1'b0;
        p1_data_q  <= '0;
        rd_valid_q <= 1'b0;
        data_out_q <= '0;
      end else begin
        p1_valid_q <= rd_req;
        if (rd_req) p1_data_q <= rd_word;
        rd_valid_q <= p1_valid_q;
        if (p1_valid_q) data_out_q <= p1_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
        data_out_q <= '0;
      end else begin
        rd_valid_q <= rd_req;
        if (rd_req) data_out_q <= rd_word;
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_rw_ram_sync_param.sv
// Directed bench: three RAM instances (latency 1, latency 2, DEPTH=3) share clock and reset
// but have independent request inputs; index 0/1/2 selects the instance.
module tb_rw_ram_sync_param;

  logic       clk;
  logic       rst;
  logic       en   [3];
  logic       we   [3];
  logic [1:0] addr [3];
  logic [3:0] din  [3];
  logic [3:0] dout [3];
  logic       rv   [3];
  logic       busy [3];

  int n_cmp = 0;
  int n_err = 0;

  rw_ram_sync_param #(
    .DATA_W(4), .ADDR_W(2), .DEPTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_lat1 (
    .clk(clk), .rst(rst), .en(en[0]), .we(we[0]), .address(addr[0]), .data_in(din[0]),
    .data_out(dout[0]), .rd_valid(rv[0]), .busy(busy[0])
  );

  rw_ram_sync_param #(
    .DATA_W(4), .ADDR_W(2), .DEPTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_lat2 (
    .clk(clk), .rst(rst), .en(en[1]), .we(we[1]), .address(addr[1]), .data_in(din[1]),
    .data_out(dout[1]), .rd_valid(rv[1]), .busy(busy[1])
  );

  rw_ram_sync_param #(
    .DATA_W(4), .ADDR_W(2), .DEPTH(3), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_d3 (
    .clk(clk), .rst(rst), .en(en[2]), .we(we[2]), .address(addr[2]), .data_in(din[2]),
    .data_out(dout[2]), .rd_valid(rv[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic e, input logic w, input logic [1:0] a,
                       input logic [3:0] d);
    en[k] = e; we[k] = w; addr[k] = a; din[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 2'd0, 4'h0);
  endtask

  task automatic test_reset();
    logic eb;
    idle_all();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (dout[k] !== 4'h0) begin n_err++; $display("FAIL rst_dout[%0d]: got %h want 0", k, dout[k]); end
      n_cmp++; if (rv[k] !== 1'b0) begin n_err++; $display("FAIL rst_rv[%0d]: got %b want 0", k, rv[k]); end
      n_cmp++; if (busy[k] !== 1'b1) begin n_err++; $display("FAIL rst_busy[%0d]: got %b want 1", k, busy[k]); end
    end
    // Reads requested throughout the clear must be dropped.
    drive(0, 1'b1, 1'b0, 2'd0, 4'h0);
    drive(1, 1'b1, 1'b0, 2'd0, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        eb = (i < ((k == 2) ? 3 : 4));
        n_cmp++; if (busy[k] !== eb) begin n_err++; $display("FAIL clr_busy[%0d] i=%0d: got %b want %b", k, i, busy[k], eb); end
        n_cmp++; if (rv[k] !== 1'b0) begin n_err++; $display("FAIL clr_rv[%0d] i=%0d: got %b want 0", k, i, rv[k]); end
      end
      if (i < 4) step();
    end
    idle_all();
    for (int a = 0; a < 4; a++) begin
      drive(0, 1'b1, 1'b0, 2'(a), 4'h0);
      if (a < 3) drive(2, 1'b1, 1'b0, 2'(a), 4'h0);
      else drive(2, 1'b0, 1'b0, 2'd0, 4'h0);
      step();
      n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h0) begin n_err++; $display("FAIL clr_read @%0d: got rv=%b d=%h want rv=1 d=0", a, rv[0], dout[0]); end
      if (a < 3) begin
        n_cmp++; if (rv[2] !== 1'b1 || dout[2] !== 4'h0) begin n_err++; $display("FAIL clr_read_d3 @%0d: got rv=%b d=%h want rv=1 d=0", a, rv[2], dout[2]); end
      end
    end
    idle_all();
    step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b1, 2'd1, 4'hA);
    step();
    n_cmp++; if (rv[0] !== 1'b0 || dout[0] !== 4'h0) begin n_err++; $display("FAIL wr_hold1: got rv=%b d=%h want rv=0 d=0", rv[0], dout[0]); end
    drive(0, 1'b1, 1'b1, 2'd2, 4'h5);
    step();
    drive(0, 1'b1, 1'b0, 2'd1, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'hA) begin n_err++; $display("FAIL rd_b2b_1: got rv=%b d=%h want rv=1 d=a", rv[0], dout[0]); end
    drive(0, 1'b1, 1'b0, 2'd2, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h5) begin n_err++; $display("FAIL rd_b2b_2: got rv=%b d=%h want rv=1 d=5", rv[0], dout[0]); end
    drive(0, 1'b0, 1'b0, 2'd0, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b0 || dout[0] !== 4'h5) begin n_err++; $display("FAIL rd_drain: got rv=%b d=%h want rv=0 d=5", rv[0], dout[0]); end
    drive(0, 1'b1, 1'b1, 2'd3, 4'h9);
    step();
    n_cmp++; if (rv[0] !== 1'b0 || dout[0] !== 4'h5) begin n_err++; $display("FAIL wr_hold2: got rv=%b d=%h want rv=0 d=5", rv[0], dout[0]); end
    idle_all();
    step();
  endtask

  task automatic test_latency2();
    drive(1, 1'b1, 1'b1, 2'd1, 4'hA);
    step();
    drive(1, 1'b1, 1'b1, 2'd2, 4'h5);
    step();
    drive(1, 1'b1, 1'b0, 2'd2, 4'h0);
    step();
    n_cmp++; if (rv[1] !== 1'b0) begin n_err++; $display("FAIL lat2_early: got rv=%b want 0", rv[1]); end
    idle_all();
    step();
    n_cmp++; if (rv[1] !== 1'b1 || dout[1] !== 4'h5) begin n_err++; $display("FAIL lat2_data: got rv=%b d=%h want rv=1 d=5", rv[1], dout[1]); end
    step();
    n_cmp++; if (rv[1] !== 1'b0 || dout[1] !== 4'h5) begin n_err++; $display("FAIL lat2_drop: got rv=%b d=%h want rv=0 d=5", rv[1], dout[1]); end
    drive(1, 1'b1, 1'b0, 2'd1, 4'h0);
    step();
    drive(1, 1'b1, 1'b0, 2'd2, 4'h0);
    step();
    n_cmp++; if (rv[1] !== 1'b1 || dout[1] !== 4'hA) begin n_err++; $display("FAIL lat2_b2b_1: got rv=%b d=%h want rv=1 d=a", rv[1], dout[1]); end
    idle_all();
    step();
    n_cmp++; if (rv[1] !== 1'b1 || dout[1] !== 4'h5) begin n_err++; $display("FAIL lat2_b2b_2: got rv=%b d=%h want rv=1 d=5", rv[1], dout[1]); end
    step();
    n_cmp++; if (rv[1] !== 1'b0) begin n_err++; $display("FAIL lat2_b2b_end: got rv=%b want 0", rv[1]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ra [3];
    logic [3:0] rd [3];
    ra[0] = 2'd0; ra[1] = 2'd3; ra[2] = 2'd0;
    rd[0] = 4'h7; rd[1] = 4'h9; rd[2] = 4'h7;
    drive(0, 1'b1, 1'b1, 2'd0, 4'h7);
    step();
    drive(0, 1'b1, 1'b0, 2'd0, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h7) begin n_err++; $display("FAIL raw_hazard: got rv=%b d=%h want rv=1 d=7", rv[0], dout[0]); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, ra[i], 4'h0);
      step();
      n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== rd[i]) begin n_err++; $display("FAIL b2b[%0d]: got rv=%b d=%h want rv=1 d=%h", i, rv[0], dout[0], rd[i]); end
    end
    idle_all();
    step();
  endtask

  task automatic test_busy_drop();
    rst = 1'b1;
    step();
    drive(0, 1'b1, 1'b1, 2'd3, 4'hC);
    drive(1, 1'b1, 1'b1, 2'd0, 4'hC);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    idle_all();
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL drop_ready: got busy=%b want 0", busy[0]); end
    drive(0, 1'b1, 1'b0, 2'd3, 4'h0);
    drive(1, 1'b1, 1'b0, 2'd0, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h0) begin n_err++; $display("FAIL drop_rd3: got rv=%b d=%h want rv=1 d=0", rv[0], dout[0]); end
    drive(0, 1'b1, 1'b0, 2'd1, 4'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 4'h0);
    step();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h0) begin n_err++; $display("FAIL drop_rd1_cleared: got rv=%b d=%h want rv=1 d=0", rv[0], dout[0]); end
    n_cmp++; if (rv[1] !== 1'b1 || dout[1] !== 4'h0) begin n_err++; $display("FAIL drop_lat2_rd0: got rv=%b d=%h want rv=1 d=0", rv[1], dout[1]); end
    idle_all();
    step();
  endtask

  task automatic test_reset_mid_clear();
    drive(0, 1'b1, 1'b1, 2'd2, 4'hB);
    drive(1, 1'b1, 1'b1, 2'd1, 4'h6);
    step();
    drive(0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1, 1'b1, 1'b0, 2'd1, 4'h0);
    step();
    n_cmp++; if (rv[1] !== 1'b0) begin n_err++; $display("FAIL inflight_pre: got rv=%b want 0", rv[1]); end
    rst = 1'b1;
    idle_all();
    #1;
    n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL async_busy: got %b want 1", busy[0]); end
    step();
    n_cmp++; if (rv[1] !== 1'b0) begin n_err++; $display("FAIL inflight_flushed: got rv=%b want 0", rv[1]); end
    rst = 1'b0;
    step();
    step();
    n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL mid_clear_busy: got %b want 1", busy[0]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (busy[0] !== (i < 4)) begin n_err++; $display("FAIL reclr_busy i=%0d: got %b want %b", i, busy[0], (i < 4)); end
      n_cmp++; if (rv[1] !== 1'b0) begin n_err++; $display("FAIL reclr_rv i=%0d: got %b want 0", i, rv[1]); end
      if (i < 4) step();
    end
    drive(0, 1'b1, 1'b0, 2'd2, 4'h0);
    step();
    idle_all();
    n_cmp++; if (rv[0] !== 1'b1 || dout[0] !== 4'h0) begin n_err++; $display("FAIL reclr_rd2: got rv=%b d=%h want rv=1 d=0", rv[0], dout[0]); end
    step();
  endtask

  task automatic test_out_of_range();
    logic [1:0] ra [5];
    logic [3:0] rd [5];
    ra[0] = 2'd2; ra[1] = 2'd3; ra[2] = 2'd0; ra[3] = 2'd1; ra[4] = 2'd2;
    rd[0] = 4'h3; rd[1] = 4'h0; rd[2] = 4'h1; rd[3] = 4'h2; rd[4] = 4'h3;
    for (int a = 0; a < 3; a++) begin
      drive(2, 1'b1, 1'b1, 2'(a), 4'(a + 1));
      step();
    end
    drive(2, 1'b1, 1'b1, 2'd3, 4'hF);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(2, 1'b1, 1'b0, ra[i], 4'h0);
      step();
      n_cmp++; if (rv[2] !== 1'b1 || dout[2] !== rd[i]) begin n_err++; $display("FAIL oor[%0d] @%0d: got rv=%b d=%h want rv=1 d=%h", i, ra[i], rv[2], dout[2], rd[i]); end
    end
    idle_all();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write_read();
    test_latency2();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid_clear();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
